// File: rtl/if_fetch_pkg.sv
// Shared pipeline defines: fetch FSM encoding and the architectural reset PC.
// Imported by the fetch stage and by the decode register.
package if_fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_REQ  = 2'd0;
    localparam fetch_state_t ST_WAIT = 2'd1;
    localparam fetch_state_t ST_HOLD = 2'd2;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // Fetch addresses are word aligned; the low two bits of any target are dropped.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one word request at a time, presents the
// returned instruction to decode, and squashes in-flight fetches on redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [63:0]        imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [31:0]        imem_resp_data,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [63:0]        if_pc,
    output logic [31:0]        if_inst,
    output fetch_state_t       dbg_state
);

    // Request channel: a request transfers on a rising edge where
    // imem_req_valid && imem_req_ready; while valid is high and ready is low the
    // address is held unchanged. Responses are accepted only in ST_WAIT.
    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;
    logic         drop_q, drop_d;
    logic         if_valid_q, if_valid_d;
    logic [63:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic [63:0]  redir_pc;
    logic         req_fire;

    assign redir_pc = word_align(redirect_pc);
    assign req_fire = (state_q == ST_REQ) && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_inst_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        case (state_q)
            ST_REQ: begin
                // A redirect here leaves the old address on the bus; its response gets dropped.
                if (redirect_valid) begin
                    pc_d   = redir_pc;
                    drop_d = 1'b1;
                end
                if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = imem_resp_data;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redir_pc;
                    state_d    = ST_REQ;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    pc_d       = pc_q + 64'd4;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
        // The bus address only moves when a fresh request phase begins.
        req_addr_d = ((state_q != ST_REQ) && (state_d == ST_REQ)) ? pc_d : req_addr_q;
    end

    always_comb begin
        imem_req_valid = (state_q == ST_REQ);
        imem_req_addr  = req_addr_q;
        if_valid       = if_valid_q;
        if_pc          = if_pc_q;
        if_inst        = if_inst_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed per-cycle vector table, then a random-stall
// stream checked against an expected-instruction queue.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [63:0] A0   = 64'h8000_0000;
    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         imem_req_valid;
    logic         imem_req_ready = 1'b0;
    logic [63:0]  imem_req_addr;
    logic         imem_resp_valid = 1'b0;
    logic [31:0]  imem_resp_data = 32'h0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = 64'h0;
    logic         id_ready = 1'b0;
    logic         if_valid;
    logic [63:0]  if_pc;
    logic [31:0]  if_inst;
    fetch_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [63:0] rpc;
        logic        idr;
        logic        exp_rqv;
        logic [63:0] exp_addr;
        logic        exp_ifv;
        logic [63:0] exp_ifpc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];
    logic [95:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic redir, input logic [63:0] rpc, input logic idr,
                       input logic e_rqv, input logic [63:0] e_addr, input logic e_ifv,
                       input logic [63:0] e_ifpc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.idr = idr;
        v.exp_rqv = e_rqv; v.exp_addr = e_addr; v.exp_ifv = e_ifv; v.exp_ifpc = e_ifpc; v.exp_inst = e_inst;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst             = v.rst;
        imem_req_ready  = v.rdy;
        imem_resp_valid = v.rv;
        imem_resp_data  = v.rdata;
        redirect_valid  = v.redir;
        redirect_pc     = v.rpc;
        id_ready        = v.idr;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic build_table();
        // reset, then sequential fetch with 1-cycle memory latency
        row(1,0,0,0,0,0,0, 1,A0,0,A0,0);
        row(1,0,0,0,0,0,0, 1,A0,0,A0,0);
        row(0,1,0,0,0,0,1, 0,A0,0,A0,0);
        row(0,1,1,32'h1111_1111,0,0,1, 0,A0,1,A0,32'h1111_1111);
        row(0,1,0,0,0,0,1, 1,A0+4,0,A0,32'h1111_1111);
        row(0,1,0,0,0,0,1, 0,A0+4,0,A0,32'h1111_1111);
        row(0,1,1,32'h2222_2222,0,0,1, 0,A0+4,1,A0+4,32'h2222_2222);
        row(0,1,0,0,0,0,1, 1,A0+8,0,A0+4,32'h2222_2222);
        row(0,1,0,0,0,0,1, 0,A0+8,0,A0+4,32'h2222_2222);
        row(0,1,1,32'h3333_3333,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        // decode stalls five cycles in HOLD; a stray response is ignored
        row(0,1,0,0,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        row(0,1,0,0,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        row(0,1,1,32'hDEAD_BEEF,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        row(0,1,0,0,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        row(0,1,0,0,0,0,0, 0,A0+8,1,A0+8,32'h3333_3333);
        row(0,1,0,0,0,0,1, 1,A0+12,0,A0+8,32'h3333_3333);
        // redirect to a misaligned target while waiting, then the stale response
        row(0,1,0,0,0,0,0, 0,A0+12,0,A0+8,32'h3333_3333);
        row(0,0,0,0,1,64'h8000_1002,0, 0,A0+12,0,A0+8,32'h3333_3333);
        row(0,0,1,32'h4444_4444,0,0,0, 1,64'h8000_1000,0,A0+8,32'h3333_3333);
        row(0,1,0,0,0,0,0, 0,64'h8000_1000,0,A0+8,32'h3333_3333);
        row(0,0,1,32'h5555_5555,0,0,0, 0,64'h8000_1000,1,64'h8000_1000,32'h5555_5555);
        row(0,0,0,0,0,0,1, 1,64'h8000_1004,0,64'h8000_1000,32'h5555_5555);
        // redirect and response in the same WAIT cycle
        row(0,1,0,0,0,0,0, 0,64'h8000_1004,0,64'h8000_1000,32'h5555_5555);
        row(0,0,1,32'h6666_6666,1,64'h8000_2000,1, 1,64'h8000_2000,0,64'h8000_1000,32'h5555_5555);
        row(0,1,0,0,0,0,0, 0,64'h8000_2000,0,64'h8000_1000,32'h5555_5555);
        row(0,0,1,32'h7777_7777,0,0,0, 0,64'h8000_2000,1,64'h8000_2000,32'h7777_7777);
        row(0,0,0,0,0,0,1, 1,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        // ready low four cycles with a redirect in between
        row(0,0,0,0,0,0,0, 1,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        row(0,0,0,0,1,64'h8000_3000,0, 1,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        row(0,0,0,0,0,0,0, 1,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        row(0,0,0,0,0,0,0, 1,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        row(0,1,0,0,0,0,0, 0,64'h8000_2004,0,64'h8000_2000,32'h7777_7777);
        row(0,0,1,32'h8888_8888,0,0,0, 1,64'h8000_3000,0,64'h8000_2000,32'h7777_7777);
        row(0,1,0,0,0,0,0, 0,64'h8000_3000,0,64'h8000_2000,32'h7777_7777);
        row(0,0,1,32'h9999_9999,0,0,0, 0,64'h8000_3000,1,64'h8000_3000,32'h9999_9999);
        // redirect in HOLD beats id_ready; then pc+4 wraps past the top of memory
        row(0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFF,1, 1,WRAP,0,64'h8000_3000,32'h9999_9999);
        row(0,1,0,0,0,0,0, 0,WRAP,0,64'h8000_3000,32'h9999_9999);
        row(0,0,1,32'hAAAA_AAAA,0,0,0, 0,WRAP,1,WRAP,32'hAAAA_AAAA);
        row(0,0,0,0,0,0,1, 1,64'h0,0,WRAP,32'hAAAA_AAAA);
        // redirect with handshake, second redirect while dropping: one response dropped
        row(0,1,0,0,1,64'h8000_4000,0, 0,64'h0,0,WRAP,32'hAAAA_AAAA);
        row(0,0,0,0,1,64'h8000_5000,0, 0,64'h0,0,WRAP,32'hAAAA_AAAA);
        row(0,0,1,32'hBBBB_BBBB,0,0,0, 1,64'h8000_5000,0,WRAP,32'hAAAA_AAAA);
        row(0,1,0,0,0,0,0, 0,64'h8000_5000,0,WRAP,32'hAAAA_AAAA);
        row(0,0,1,32'hCCCC_CCCC,0,0,0, 0,64'h8000_5000,1,64'h8000_5000,32'hCCCC_CCCC);
        // reset mid-transaction; the late response is not captured
        row(0,0,0,0,0,0,1, 1,64'h8000_5004,0,64'h8000_5000,32'hCCCC_CCCC);
        row(0,1,0,0,0,0,0, 0,64'h8000_5004,0,64'h8000_5000,32'hCCCC_CCCC);
        row(1,0,0,0,0,0,0, 1,A0,0,A0,32'h0);
        row(0,0,1,32'hDDDD_DDDD,0,0,0, 1,A0,0,A0,32'h0);
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic        pending;
        int          lat;
        int          consumed;
        logic [95:0] e;

        build_table();
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].exp_rqv});
            check($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].exp_addr);
            check($sformatf("row%0d if_valid", i), {63'h0, if_valid}, {63'h0, vecs[i].exp_ifv});
            check($sformatf("row%0d if_pc", i), if_pc, vecs[i].exp_ifpc);
            check($sformatf("row%0d if_inst", i), {32'h0, if_inst}, {32'h0, vecs[i].exp_inst});
        end

        // Random stalls on memory and decode; the DUT is in REQ at RESET_PC here.
        exp_pc   = A0;
        pending  = 1'b0;
        lat      = 0;
        consumed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst             = 1'b0;
            redirect_valid  = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            imem_req_ready  = ($urandom_range(0, 3) != 0);
            id_ready        = ($urandom_range(0, 2) != 0);
            if (pending) begin
                if (lat == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(exp_pc);
                    exp_q.push_back({exp_pc, mem_word(exp_pc)});
                    exp_pc  = exp_pc + 64'd4;
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                check("stream req_addr", imem_req_addr, exp_pc);
                pending = 1'b1;
                lat     = $urandom_range(0, 3);
            end
            if (if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected instruction", {63'h0, if_valid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream if_pc", if_pc, e[95:32]);
                    check("stream if_inst", {32'h0, if_inst}, {32'h0, e[31:0]});
                    consumed++;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("stream progress", {63'h0, consumed >= 20}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the fetch address after reset.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request pending.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  64  fetch address, low 2 bits always 0.
REQ-007 imem_resp_valid  input  1  instruction word returned.
REQ-008 imem_resp_data  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump/trap redirect from later stage.
REQ-010 redirect_pc  input  64  redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-011 id_ready  input  1  decode register enable; drives the decode-stage ena.
REQ-012 if_valid  output  1  if_pc/if_inst hold a valid instruction.
REQ-013 if_pc  output  64  PC of presented instruction.
REQ-014 if_inst  output  32  presented instruction.

Function
REQ-015 The block SHALL implement an FSM with states REQ, WAIT and HOLD, with one outstanding memory request at most.
REQ-016 REQ: imem_req_valid=1 and imem_req_addr=pc; on imem_req_valid&imem_req_ready, go to WAIT.
REQ-017 imem_req_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0.
REQ-018 WAIT: on imem_resp_valid with drop=0, capture if_inst<=imem_resp_data, if_pc<=pc, if_valid<=1, and go to HOLD.
REQ-019 HOLD: if_valid=1; on id_ready=1, set pc<=pc+4 (mod 2^64), clear if_valid, and go to REQ.
REQ-020 Minimum throughput SHALL be one instruction per 3 cycles with zero-latency memory.
REQ-021 Redirect SHALL have priority over every other event in the same cycle.
REQ-022 Redirect in HOLD: if_valid<=0, pc<=redirect_pc, go to REQ; the held instruction is discarded even if id_ready=1.
REQ-023 Redirect in REQ without handshake: pc<=redirect_pc and drop<=1, stay in REQ; the old address stays on the bus (REQ-017), and its response is discarded.
REQ-024 Redirect in REQ with handshake in the same cycle: pc<=redirect_pc, drop<=1, go to WAIT.
REQ-025 Redirect in WAIT without response: pc<=redirect_pc, drop<=1, stay in WAIT.
REQ-026 Redirect in WAIT with response in the same cycle: discard the response, pc<=redirect_pc, drop<=0, go to REQ.
REQ-027 Response in WAIT with drop=1: discard it, clear drop, go to REQ with the current pc; if_valid stays 0.
REQ-028 A second redirect while drop=1 SHALL overwrite pc only; at most one response is discarded.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored.
REQ-030 if_valid, if_pc and if_inst SHALL be registered outputs; imem_req_valid SHALL be decoded from the state register only.

Reset
REQ-031 On rst: state=REQ, pc=RESET_PC, drop=0, if_valid=0, if_pc=RESET_PC, if_inst=32'h0.
REQ-032 rst mid-transaction SHALL abandon any outstanding request; the first post-reset response SHALL NOT be captured unless it answers a post-reset request.
REQ-033 imem_req_valid SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 State encoding localparams and RESET_PC SHALL live in the shared pipeline defines package, also used by the decode register.
REQ-035 The block SHALL be a single module with no sub-modules; the pc+4 adder is inline.

Verification
REQ-036 The bench SHALL cover the reset directed scenarios in REQ-037 to REQ-041.
REQ-037 Reset release, mem ready=1, 1-cycle latency, id_ready=1: addresses are 0x80000000, 0x80000004 and 0x80000008, each presented with if_valid for one cycle.
REQ-038 id_ready=0 for 5 cycles in HOLD: if_pc and if_inst stay constant, and no new imem request is made.
REQ-039 Redirect to 0x80001002 in WAIT, then a response: the response is dropped, and the next request address is 0x80001000.
REQ-040 Redirect and response in the same WAIT cycle: no if_valid pulse, and the next request goes to the redirect target.
REQ-041 imem_req_ready held low for 4 cycles with a redirect in between: address stays stable until accepted, and the stale response is dropped.
REQ-042 pc=64'hFFFF_FFFF_FFFF_FFFC with id_ready: the next request address wraps to 0.
